// File: rtl/mic_lag_estimator_if.sv
// Sample strobe/data and lag result signals of one microphone-pair lag estimator.
interface mic_lag_estimator_if #(
  parameter int DW    = 16,
  parameter int ACC_W = 40
);
  logic                    sample_valid;
  logic signed [DW-1:0]    mic_ref;
  logic signed [DW-1:0]    mic_cmp;
  logic signed [5:0]       lag_diff;
  logic                    lag_valid;
  logic signed [ACC_W-1:0] peak_corr;
  logic                    confident;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sample_valid, mic_ref, mic_cmp,
    input  lag_diff, lag_valid, peak_corr, confident, busy, overrun
  );

  modport slave (
    input  sample_valid, mic_ref, mic_cmp,
    output lag_diff, lag_valid, peak_corr, confident, busy, overrun
  );
endinterface

// File: rtl/mic_lag_estimator.sv
// Captures a frame from two microphones, then sweeps the cross-correlation over
// lags -MAX_LAG..+MAX_LAG with one MAC and reports the lag of the peak.
module mic_lag_estimator #(
  parameter int DW       = 16,
  parameter int WIN      = 256,
  parameter int MAX_LAG  = 31,
  parameter int ACC_W    = 2*DW + $clog2(WIN),
  parameter int PEAK_MIN = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  mic_lag_estimator_if.slave  bus
);

  localparam int AW = $clog2(WIN);
  localparam int PW = 2*DW;
  localparam logic [AW-1:0]           LastWr  = AW'(WIN-1);
  localparam logic [AW:0]             LastCnt = (AW+1)'(WIN+1);
  localparam logic signed [5:0]       LagMin  = 6'(-MAX_LAG);
  localparam logic signed [5:0]       LagMax  = 6'(MAX_LAG);
  localparam logic signed [ACC_W-1:0] AccMin  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] PeakMin = ACC_W'(PEAK_MIN);

  typedef enum logic [1:0] {FILL, CALC, DONE} state_e;

  state_e                  state_q;
  logic signed [DW-1:0]    refMem [WIN];
  logic signed [DW-1:0]    cmpMem [WIN];
  logic signed [DW-1:0]    refRd_q, cmpRd_q;
  logic [AW-1:0]           wrCnt_q;
  logic [AW:0]             cnt_q;
  logic signed [5:0]       lag_q, bestLag_q;
  logic                    vld1_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [ACC_W-1:0] acc_q, best_q;
  logic signed [5:0]       lagDiff_q;
  logic                    lagValid_q, confident_q, busy_q, overrun_q;
  logic signed [ACC_W-1:0] peakCorr_q;

  logic                    accept_d;
  logic signed [AW+1:0]    issueIdx_d;
  logic                    issueVld_d;
  logic signed [ACC_W-1:0] prodExt_d, accSum_d;

  // busy_q trails the state by one cycle, so the lag_valid cycle still refuses samples.
  always_comb begin
    accept_d   = bus.sample_valid && (state_q == FILL) && !busy_q;
    issueIdx_d = {2'b00, cnt_q[AW-1:0]} + {{(AW-4){lag_q[5]}}, lag_q};
    issueVld_d = (state_q == CALC) && !cnt_q[AW] && !issueIdx_d[AW+1] && !issueIdx_d[AW];
    prodExt_d  = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
    accSum_d   = acc_q + prodExt_d;
  end

  always_ff @(posedge clk) begin
    if (accept_d) begin
      refMem[wrCnt_q] <= bus.mic_ref;
      cmpMem[wrCnt_q] <= bus.mic_cmp;
    end
    refRd_q <= refMem[cnt_q[AW-1:0]];
    cmpRd_q <= cmpMem[issueIdx_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wrCnt_q     <= '0;
      cnt_q       <= '0;
      lag_q       <= '0;
      bestLag_q   <= '0;
      vld1_q      <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      lagDiff_q   <= '0;
      lagValid_q  <= 1'b0;
      peakCorr_q  <= '0;
      confident_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      lagValid_q <= 1'b0;
      overrun_q  <= bus.sample_valid && !accept_d;
      busy_q     <= (state_q != FILL);
      vld1_q     <= issueVld_d;
      prod_q     <= vld1_q ? PW'(refRd_q) * PW'(cmpRd_q) : '0;
      unique case (state_q)
        FILL: begin
          if (accept_d) begin
            wrCnt_q <= wrCnt_q + 1'b1;
            if (wrCnt_q == LastWr) begin
              wrCnt_q   <= '0;
              state_q   <= CALC;
              cnt_q     <= '0;
              lag_q     <= LagMin;
              acc_q     <= '0;
              best_q    <= AccMin;
              bestLag_q <= LagMin;
            end
          end
        end
        CALC: begin
          acc_q <= accSum_d;
          // Last drain cycle: the final product of this lag is still in prod_q.
          if (cnt_q == LastCnt) begin
            acc_q <= '0;
            cnt_q <= '0;
            if (accSum_d > best_q) begin
              best_q    <= accSum_d;
              bestLag_q <= lag_q;
            end
            if (lag_q == LagMax) state_q <= DONE;
            else                 lag_q   <= lag_q + 6'sd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          lagDiff_q   <= bestLag_q;
          peakCorr_q  <= best_q;
          confident_q <= (best_q > PeakMin);
          lagValid_q  <= 1'b1;
          wrCnt_q     <= '0;
          state_q     <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.lag_diff  = lagDiff_q;
  assign bus.lag_valid = lagValid_q;
  assign bus.peak_corr = peakCorr_q;
  assign bus.confident = confident_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mic_lag_estimator.sv
// Frame-level bench for mic_lag_estimator: a correlation model queues the expected
// result of each frame and each scenario task pops and compares it on lag_valid.
module tb_mic_lag_estimator;
  localparam int DW      = 16;
  localparam int WIN     = 256;
  localparam int MAX_LAG = 31;
  localparam int ACC_W   = 40;
  localparam int LAT     = (2*MAX_LAG+1)*(WIN+2)+1;

  typedef struct {
    int     lag;
    longint peak;
    bit     conf;
  } expRes_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   fails = 0;
  logic signed [DW-1:0] refBuf [WIN];
  logic signed [DW-1:0] cmpBuf [WIN];
  expRes_t expQ[$];

  mic_lag_estimator_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

  mic_lag_estimator #(
    .DW(DW), .WIN(WIN), .MAX_LAG(MAX_LAG), .ACC_W(ACC_W), .PEAK_MIN(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic void clearFrame();
    for (int i = 0; i < WIN; i++) begin
      refBuf[i] = '0;
      cmpBuf[i] = '0;
    end
  endfunction

  // Direct cross-correlation over all lags, strict > so the lowest lag wins ties.
  function automatic void pushExpected();
    expRes_t e;
    longint  sum;
    longint  best;
    int      bestLag;
    best    = -(64'sd1 <<< (ACC_W-1));
    bestLag = -MAX_LAG;
    for (int k = -MAX_LAG; k <= MAX_LAG; k++) begin
      sum = 0;
      for (int n = 0; n < WIN; n++)
        if (n + k >= 0 && n + k < WIN)
          sum += longint'(refBuf[n]) * longint'(cmpBuf[n+k]);
      if (sum > best) begin
        best    = sum;
        bestLag = k;
      end
    end
    e.lag  = bestLag;
    e.peak = best;
    e.conf = (best > 0);
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(output int t0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < WIN; i++) begin
      bus.sample_valid = 1'b1;
      bus.mic_ref      = refBuf[i];
      bus.mic_cmp      = cmpBuf[i];
      @(posedge clk);
      #1;
    end
    bus.sample_valid = 1'b0;
    t0 = cycle;
  endtask

  task automatic waitLagValid(input int budget, output bit seen, output int edgeNum);
    seen    = 1'b0;
    edgeNum = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.lag_valid === 1'b1) begin
        seen    = 1'b1;
        edgeNum = cycle;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.lag_valid, bus.confident, bus.busy, bus.overrun} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000",
               {bus.lag_valid, bus.confident, bus.busy, bus.overrun});
    end
    checks++;
    if (bus.lag_diff !== 6'sd0 || bus.peak_corr !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: lag %0d peak %0d, expected 0 and 0",
               bus.lag_diff, bus.peak_corr);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < WIN-1; i++) begin
      bus.sample_valid = 1'b1;
      bus.mic_ref      = 16'sd0;
      bus.mic_cmp      = 16'sd0;
      @(posedge clk);
      #1;
    end
    bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_after_255: got %b, expected 0", bus.busy);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_impulse_overrun();
    int t0, edgeNum;
    bit seen;
    expRes_t e;
    clearFrame();
    refBuf[100] = 16'sd1000;
    cmpBuf[105] = 16'sd1000;
    pushExpected();
    applyStimulus(t0);
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_at_t0: got %b, expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_rise: got %b, expected 1", bus.busy);
    end
    repeat (99) @(posedge clk);
    #1;
    checks++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overrun_idle: got %b, expected 0", bus.overrun);
    end
    bus.sample_valid = 1'b1;
    bus.mic_ref      = 16'sd1234;
    bus.mic_cmp      = -16'sd1234;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overrun_pulse: got %b, expected 1", bus.overrun);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overrun_width: got %b, expected 0", bus.overrun);
    end
    waitLagValid(LAT + 100, seen, edgeNum);
    checks++;
    if (!seen || expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL impulse_valid: seen %0d queued %0d, expected 1 and 1", seen, expQ.size());
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.lag_diff !== 6'(e.lag)) begin
        fails++;
        $display("[TB] FAIL impulse_lag: got %0d, expected %0d", bus.lag_diff, e.lag);
      end
      checks++;
      if (bus.peak_corr !== ACC_W'(e.peak)) begin
        fails++;
        $display("[TB] FAIL impulse_peak: got %0d, expected %0d", bus.peak_corr, e.peak);
      end
      checks++;
      if (bus.confident !== e.conf) begin
        fails++;
        $display("[TB] FAIL impulse_conf: got %b, expected %b", bus.confident, e.conf);
      end
      checks++;
      if (edgeNum != t0 + LAT) begin
        fails++;
        $display("[TB] FAIL impulse_latency: got T0+%0d, expected T0+%0d", edgeNum - t0, LAT);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL busy_in_done: got %b, expected 1", bus.busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.lag_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL busy_fall: busy %b lag_valid %b, expected 0 and 0", bus.busy, bus.lag_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, edgeNum;
    bit seen;
    expRes_t e;
    clearFrame();
    refBuf[100] = 16'sd1000;
    cmpBuf[69]  = 16'sd1000;
    pushExpected();
    applyStimulus(t0);
    checks++;
    if (bus.lag_diff !== 6'sd5) begin
      fails++;
      $display("[TB] FAIL lag_held: got %0d, expected 5", bus.lag_diff);
    end
    waitLagValid(LAT + 100, seen, edgeNum);
    checks++;
    if (!seen || expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL neg_edge_valid: seen %0d queued %0d, expected 1 and 1", seen, expQ.size());
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.lag_diff !== 6'(e.lag) || bus.peak_corr !== ACC_W'(e.peak)) begin
        fails++;
        $display("[TB] FAIL neg_edge_result: lag %0d peak %0d, expected %0d and %0d",
                 bus.lag_diff, bus.peak_corr, e.lag, e.peak);
      end
      checks++;
      if (edgeNum != t0 + LAT) begin
        fails++;
        $display("[TB] FAIL neg_edge_latency: got T0+%0d, expected T0+%0d", edgeNum - t0, LAT);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int t0, edgeNum;
    bit seen;
    expRes_t e;
    clearFrame();
    refBuf[100] = 16'sd1000;
    cmpBuf[109] = 16'sd1000;
    applyStimulus(t0);
    repeat (5000) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_mid_calc: got %b, expected 1", bus.busy);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.lag_valid !== 1'b0 || bus.lag_diff !== 6'sd0) begin
      fails++;
      $display("[TB] FAIL abort_reset: busy %b valid %b lag %0d, expected 0 0 0",
               bus.busy, bus.lag_valid, bus.lag_diff);
    end
    rst_n = 1'b1;
    clearFrame();
    refBuf[100] = 16'sd1000;
    cmpBuf[131] = 16'sd1000;
    pushExpected();
    applyStimulus(t0);
    waitLagValid(LAT + 100, seen, edgeNum);
    checks++;
    if (!seen || expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL pos_edge_valid: seen %0d queued %0d, expected 1 and 1", seen, expQ.size());
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.lag_diff !== 6'(e.lag) || bus.peak_corr !== ACC_W'(e.peak)) begin
        fails++;
        $display("[TB] FAIL pos_edge_result: lag %0d peak %0d, expected %0d and %0d",
                 bus.lag_diff, bus.peak_corr, e.lag, e.peak);
      end
      checks++;
      if (edgeNum != t0 + LAT) begin
        fails++;
        $display("[TB] FAIL abort_latency: got T0+%0d, expected T0+%0d", edgeNum - t0, LAT);
      end
    end
  endtask

  task automatic test_out_of_range();
    int t0, edgeNum;
    bit seen;
    expRes_t e;
    clearFrame();
    refBuf[100] = 16'sd1000;
    cmpBuf[140] = 16'sd1000;
    pushExpected();
    applyStimulus(t0);
    waitLagValid(LAT + 100, seen, edgeNum);
    checks++;
    if (!seen || expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL tie_valid: seen %0d queued %0d, expected 1 and 1", seen, expQ.size());
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.lag_diff !== 6'(e.lag)) begin
        fails++;
        $display("[TB] FAIL tie_lag: got %0d, expected %0d", bus.lag_diff, e.lag);
      end
      checks++;
      if (bus.peak_corr !== ACC_W'(e.peak) || bus.confident !== e.conf) begin
        fails++;
        $display("[TB] FAIL tie_peak_conf: peak %0d conf %b, expected %0d and %b",
                 bus.peak_corr, bus.confident, e.peak, e.conf);
      end
    end
  endtask

  task automatic test_full_scale();
    int t0, edgeNum;
    bit seen;
    expRes_t e;
    for (int i = 0; i < WIN; i++) begin
      refBuf[i] = -16'sd32768;
      cmpBuf[i] = -16'sd32768;
    end
    pushExpected();
    applyStimulus(t0);
    waitLagValid(LAT + 100, seen, edgeNum);
    checks++;
    if (!seen || expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL full_valid: seen %0d queued %0d, expected 1 and 1", seen, expQ.size());
    end else begin
      e = expQ.pop_front();
      checks++;
      if (bus.lag_diff !== 6'(e.lag)) begin
        fails++;
        $display("[TB] FAIL full_lag: got %0d, expected %0d", bus.lag_diff, e.lag);
      end
      checks++;
      if (bus.peak_corr !== ACC_W'(e.peak)) begin
        fails++;
        $display("[TB] FAIL full_peak: got %0d, expected %0d", bus.peak_corr, e.peak);
      end
      checks++;
      if (bus.confident !== e.conf) begin
        fails++;
        $display("[TB] FAIL full_conf: got %b, expected %b", bus.confident, e.conf);
      end
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.mic_ref      = '0;
    bus.mic_cmp      = '0;
    test_reset();
    test_impulse_overrun();
    test_back_to_back();
    test_reset_mid_calc();
    test_out_of_range();
    test_full_scale();
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
